dpt_gate_sequencer: RTL

Double-pulse test gate sequencer; sits directly downstream of the debounce stage and consumes its cleaned trigger level (K1). On each fresh trigger rise it emits one exact double-pulse on the DUT low-side gate, with optional complementary high-side conduction during the gap and enforced dead time. A hold-off window follows each sequence. A latched fault path forces both gates off.

---
 rtl/dpt_gate_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dpt_gate_sequencer.sv
// Double-pulse test gate sequencer: one exact lo/gap/lo pulse train per trigger rise,
// optional high-side conduction in the gap, dead time, hold-off and a latched fault path.
module dpt_gate_sequencer #(
  parameter int unsigned T1_CYC      = 3000,
  parameter int unsigned TOFF_CYC    = 2000,
  parameter int unsigned T2_CYC      = 3000,
  parameter int unsigned DEAD_CYC    = 20,
  parameter int unsigned HOLDOFF_CYC = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_trig,
  input  logic i_sync_en,
  input  logic i_fault_n,
  output logic o_gate_lo,
  output logic o_gate_hi,
  output logic o_busy,
  output logic o_done,
  output logic o_fault_latched
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_P1    = 3'd1,
    S_DTA   = 3'd2,
    S_GAP   = 3'd3,
    S_DTB   = 3'd4,
    S_P2    = 3'd5,
    S_HOLD  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  // Counter reload values: each phase lasts exactly (load + 1) cycles.
  localparam logic [23:0] C_T1   = 24'(T1_CYC - 1);
  localparam logic [23:0] C_TOFF = 24'(TOFF_CYC - 1);
  localparam logic [23:0] C_T2   = 24'(T2_CYC - 1);
  localparam logic [23:0] C_DEAD = 24'(DEAD_CYC - 1);
  localparam logic [23:0] C_HOLD = 24'(HOLDOFF_CYC - 1);

  state_t      r_state;
  logic [23:0] r_cnt;
  logic        r_trig_q;
  logic        r_sync_q;
  logic        r_fault_meta;
  logic        r_fault_sync;
  logic        r_gate_lo;
  logic        r_gate_hi;
  logic        r_busy;
  logic        r_done;
  logic        r_fault_latched;

  logic w_fault_s;
  logic w_rise;
  logic w_cnt_zero;

  assign w_fault_s  = ~r_fault_sync;
  assign w_rise     = i_trig & ~r_trig_q;
  assign w_cnt_zero = (r_cnt == 24'd0);

  assign o_gate_lo       = r_gate_lo;
  assign o_gate_hi       = r_gate_hi;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_fault_latched = r_fault_latched;

  // Sequencer FSM with fault synchronizer, trigger edge register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= 24'd0;
      r_trig_q        <= 1'b0;
      r_sync_q        <= 1'b0;
      r_fault_meta    <= 1'b1;
      r_fault_sync    <= 1'b1;
      r_gate_lo       <= 1'b0;
      r_gate_hi       <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_trig_q     <= i_trig;
      r_fault_meta <= i_fault_n;
      r_fault_sync <= r_fault_meta;
      r_done       <= 1'b0;
      if (w_fault_s) begin
        r_state         <= S_FAULT;
        r_cnt           <= 24'd0;
        r_gate_lo       <= 1'b0;
        r_gate_hi       <= 1'b0;
        r_busy          <= 1'b0;
        r_fault_latched <= 1'b1;
      end else if (!i_enable) begin
        // Abort drops straight to IDLE, skipping hold-off; also the only exit from FAULT.
        r_state         <= S_IDLE;
        r_cnt           <= 24'd0;
        r_gate_lo       <= 1'b0;
        r_gate_hi       <= 1'b0;
        r_busy          <= 1'b0;
        r_fault_latched <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_state   <= S_P1;
              r_cnt     <= C_T1;
              r_sync_q  <= i_sync_en;
              r_gate_lo <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_P1: begin
            if (w_cnt_zero) begin
              r_state   <= S_DTA;
              r_cnt     <= C_DEAD;
              r_gate_lo <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          S_DTA: begin
            if (w_cnt_zero) begin
              r_state   <= S_GAP;
              r_cnt     <= C_TOFF;
              r_gate_hi <= r_sync_q;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          S_GAP: begin
            if (w_cnt_zero) begin
              r_state   <= S_DTB;
              r_cnt     <= C_DEAD;
              r_gate_hi <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          S_DTB: begin
            if (w_cnt_zero) begin
              r_state   <= S_P2;
              r_cnt     <= C_T2;
              r_gate_lo <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          S_P2: begin
            if (w_cnt_zero) begin
              r_state   <= S_HOLD;
              r_cnt     <= C_HOLD;
              r_gate_lo <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          S_HOLD: begin
            if (w_cnt_zero) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          S_FAULT: begin
            r_state <= S_FAULT;
          end
          default: begin
            r_state         <= S_IDLE;
            r_cnt           <= 24'd0;
            r_gate_lo       <= 1'b0;
            r_gate_hi       <= 1'b0;
            r_busy          <= 1'b0;
            r_fault_latched <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
